// File: rtl/add_op_sequencer_pkg.sv
// Shared types and constants for the adder operation sequencer.
// Optional overflow output is enabled by defining ADD_OP_SEQUENCER_OVF_EN.
package add_op_sequencer_pkg;

    localparam int N_DEF      = 32;
    localparam int SETTLE_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } state_e;

    // Signed overflow: operands agree in sign but the sum does not.
    function automatic logic ovf_flag(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/add_op_sequencer_if.sv
// Upstream, adder and downstream signal bundle for add_op_sequencer.
// out_ovf is present only when ADD_OP_SEQUENCER_OVF_EN is defined.
interface add_op_sequencer_if
    import add_op_sequencer_pkg::*;
#(
    parameter int N = N_DEF
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_a;
    logic [N-1:0] in_b;
    logic [N-1:0] add_a;
    logic [N-1:0] add_b;
    logic [N-1:0] add_s;
    logic         add_c;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_sum;
    logic         out_carry;
`ifdef ADD_OP_SEQUENCER_OVF_EN
    logic         out_ovf;

    modport master (
        output in_valid, in_a, in_b, add_s, add_c, out_ready,
        input  in_ready, add_a, add_b, out_valid, out_sum, out_carry, out_ovf
    );
    modport slave (
        input  in_valid, in_a, in_b, add_s, add_c, out_ready,
        output in_ready, add_a, add_b, out_valid, out_sum, out_carry, out_ovf
    );
`else
    modport master (
        output in_valid, in_a, in_b, add_s, add_c, out_ready,
        input  in_ready, add_a, add_b, out_valid, out_sum, out_carry
    );
    modport slave (
        input  in_valid, in_a, in_b, add_s, add_c, out_ready,
        output in_ready, add_a, add_b, out_valid, out_sum, out_carry
    );
`endif

endinterface

// File: rtl/add_op_sequencer_settle_timer.sv
// Saturating settle down-counter: load SETTLE-1, decrement to zero, flag zero.
module settle_timer #(
    parameter int SETTLE = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_load,
    input  logic i_dec,
    output logic o_zero
);
    localparam int            CW       = $clog2(SETTLE + 1);
    localparam logic [CW-1:0] LOAD_VAL = CW'(SETTLE - 1);

    logic [CW-1:0] r_count;

    // Counter register; holds at zero instead of wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= LOAD_VAL;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - CW'(1);
        end else begin
            r_count <= r_count;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/add_op_sequencer.sv
// Sequences one operand pair through an external ripple adder and holds the result.
// Define ADD_OP_SEQUENCER_OVF_EN to add the signed-overflow output out_ovf.
module add_op_sequencer
    import add_op_sequencer_pkg::*;
#(
    parameter int N      = N_DEF,
    parameter int SETTLE = SETTLE_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    add_op_sequencer_if.slave    bus,
    output logic                 busy
);
    state_e       r_state;
    logic         r_in_ready;
    logic         r_out_valid;
    logic         r_busy;
    logic [N-1:0] r_add_a;
    logic [N-1:0] r_add_b;
    logic [N-1:0] r_out_sum;
    logic         r_out_carry;
`ifdef ADD_OP_SEQUENCER_OVF_EN
    logic         r_out_ovf;
`endif

    logic w_load;
    logic w_dec;
    logic w_zero;

    assign w_load = (r_state == ST_IDLE) && bus.in_valid;
    assign w_dec  = (r_state == ST_SETTLE);

    settle_timer #(.SETTLE(SETTLE)) u_settle_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_load),
        .i_dec  (w_dec),
        .o_zero (w_zero)
    );

    // Sequencer FSM with all outputs registered; operands change only on accept.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_add_a     <= '0;
            r_add_b     <= '0;
            r_out_sum   <= '0;
            r_out_carry <= 1'b0;
`ifdef ADD_OP_SEQUENCER_OVF_EN
            r_out_ovf   <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        r_add_a    <= bus.in_a;
                        r_add_b    <= bus.in_b;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= ST_SETTLE;
                    end else begin
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b0;
                    end
                end
                ST_SETTLE: begin
                    if (w_zero) begin
                        r_out_sum   <= bus.add_s;
                        r_out_carry <= bus.add_c;
`ifdef ADD_OP_SEQUENCER_OVF_EN
                        r_out_ovf   <= ovf_flag(r_add_a[N-1], r_add_b[N-1], bus.add_s[N-1]);
`endif
                        r_out_valid <= 1'b1;
                        r_state     <= ST_HOLD;
                    end else begin
                        r_state     <= ST_SETTLE;
                    end
                end
                ST_HOLD: begin
                    // The accepting edge returns to IDLE, so the next accept is a cycle later.
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_state     <= ST_HOLD;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.add_a     = r_add_a;
    assign bus.add_b     = r_add_b;
    assign bus.out_sum   = r_out_sum;
    assign bus.out_carry = r_out_carry;
`ifdef ADD_OP_SEQUENCER_OVF_EN
    assign bus.out_ovf   = r_out_ovf;
`endif
    assign busy          = r_busy;

endmodule
